lsu_dmem_ctrl: RTL
==================

// Module: lsu_dmem_ctrl
// PURPOSE
//  MEM-stage load/store unit: issues RV32 loads and stores to the data memory over a req/gnt/rvalid handshake.
//  Formats load data (sign or zero extension, byte-lane select) and builds store byte enables.
//  Holds the pipeline with lsu_stall until the access completes. This stall is raised from the memory side;
//  the decode-side load-use detector raises its own stall separately, and the two are ORed in pipeline control.
// PARAMETERS
//  MAX_WAIT  64  cycles in REQ+WAIT before the access is abandoned with timeout_err
//  CNT_W     7   width of the wait counter; must satisfy 2**CNT_W > MAX_WAIT
// PORTS
//  clk           in   1   rising-edge clock
//  rst_n         in   1   asynchronous, active-low reset
//  instr_mem     in   32  instruction in the MEM stage: opcode [6:0], funct3 [14:12]
//  valid_mem     in   1   instr_mem is a live (non-bubble) instruction
//  flush         in   1   squash the access in flight
//  addr_mem      in   32  effective address (ALU result)
//  wdata_mem     in   32  store data (rs2 value)
//  dmem_req      out  1   request valid
//  dmem_we       out  1   1 = store, 0 = load
//  dmem_be       out  4   byte enables
//  dmem_addr     out  32  word-aligned address, {addr[31:2],2'b00}
//  dmem_wdata    out  32  lane-replicated store data
//  dmem_gnt      in   1   request accepted
//  dmem_rvalid   in   1   load data valid
//  dmem_rdata    in   32  load data
//  lsu_stall     out  1   hold IF/ID/EX/MEM; insert a bubble into WB
//  load_data     out  32  formatted load result, valid with load_valid
//  load_valid    out  1   1-cycle pulse
//  misalign_err  out  1   1-cycle pulse
//  timeout_err   out  1   1-cycle pulse
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including load_data, counter and captured registers.
//  mem_op = valid_mem & (opcode==7'b0000011 LOAD | opcode==7'b0100011 STORE).
//  Alignment: LH/LHU/SH need addr[0]==0; LW/SW need addr[1:0]==0; byte accesses are always aligned.
//  IDLE:
//   - mem_op & aligned & !flush: lsu_stall=1 combinationally this cycle. Capture addr, be, wdata, funct3, we. Go to REQ.
//   - mem_op & misaligned: misalign_err pulses next cycle. No request, no stall, stay in IDLE.
//  REQ: dmem_req=1; addr/be/we/wdata are held stable until gnt.
//   - gnt & store -> DONE.
//   - gnt & load & rvalid in the same cycle -> capture data -> DONE.
//   - gnt & load (no rvalid) -> WAIT.
//   - flush before gnt -> drop req next cycle -> IDLE.
//  WAIT: dmem_req=0.
//   - rvalid -> load_data is registered from formatted rdata -> DONE.
//   - flush -> DRAIN.
//  DRAIN: lsu_stall=1 until rvalid; data discarded, load_valid stays 0 -> IDLE.
//  DONE: lsu_stall=0 so the pipeline advances. load_valid=1 for loads only. Unconditionally -> IDLE;
//   the stale instr_mem still present this cycle is not re-sampled.
//  lsu_stall = (IDLE & start) | REQ | WAIT | DRAIN.
//  Timeout: counter clears on entering REQ and increments each cycle in REQ/WAIT/DRAIN.
//   At count==MAX_WAIT-1 without completion: timeout_err pulse, dmem_req drops, -> IDLE.
//   A later late rvalid in IDLE is ignored.
//  Loads: byte lane = addr[1:0], half = addr[1].
//   funct3 000 LB sign-extend; 001 LH sign-extend; 010 LW; 100 LBU zero-extend; 101 LHU zero-extend.
//   Other funct3 values are treated as LW.
//  Stores: SB be=4'b0001<<addr[1:0], wdata={4{w[7:0]}}; SH be=4'b0011<<{addr[1],1'b0}, wdata={2{w[15:0]}};
//   SW be=4'b1111.
//  Stores never pulse load_valid. Back-to-back memory ops cost >= 3 cycles each (IDLE, REQ, DONE).
//  Reset mid-access: immediate return to IDLE, dmem_req drops asynchronously.
// STRUCTURE
//  Shared package: OPC_LOAD, OPC_STORE, funct3 codes (F3_B/H/W/BU/HU), lsu_state_t {IDLE,REQ,WAIT,DRAIN,DONE}.
//  Sub-module lsu_load_align (combinational): funct3, addr[1:0], rdata -> load_data.
//   It is reused by the forwarding path.
//  Top level holds the FSM, capture registers, counter and store lane logic.
// TESTING
//  1 LW addr 0x100, gnt on cycle 2, rvalid 3 cycles later, rdata 0xDEADBEEF
//    -> stall for 5 cycles, load_valid with 0xDEADBEEF, dmem_addr 0x100.
//  2 LB addr 0x103 rdata 0x80FF_FF_FF -> load_data 0xFFFFFF80; LBU same -> 0x00000080;
//    LHU addr 0x102 -> 0x000080FF.
//  3 SB addr 0x201 wdata 0x12345678, gnt immediate
//    -> be 4'b0010, dmem_wdata 0x78787878, we=1, no load_valid, stall 2 cycles.
//  4 LW addr 0x102 -> misalign_err 1 cycle, dmem_req never asserted, lsu_stall 0.
//  5 LW with flush asserted in WAIT -> DRAIN; rvalid 0xAAAA5555 discarded; load_valid 0;
//    stall drops the cycle after rvalid.
//  6 gnt never asserted, MAX_WAIT=8 -> timeout_err after 8 cycles, dmem_req 0;
//    rst_n low mid-REQ -> all outputs 0 at once.

Source files
------------

// File: rtl/lsu_dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_dmem_ctrl_pkg
//  Description : Shared opcodes, funct3 codes, LSU state encoding and an
//                alignment helper for the MEM-stage load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_dmem_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } lsu_state_t;

    // size_code is funct3[1:0]: 00 byte, 01 half, anything else word
    function automatic logic is_aligned(input logic [1:0] size_code, input logic [1:0] addr_lo);
        case (size_code)
            2'b00:   return 1'b1;
            2'b01:   return ~addr_lo[0];
            default: return (addr_lo == 2'b00);
        endcase
    endfunction

endpackage : lsu_dmem_ctrl_pkg
`default_nettype wire

// File: rtl/lsu_dmem_ctrl_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_load_align
//  Description : Combinational load formatter: selects the byte/half lane
//                from a 32-bit read word and sign- or zero-extends it.
//                Shared with the forwarding path.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_dmem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select then extension; unknown funct3 codes behave as a full word
    always_comb begin
        w_byte = rdata[7:0];
        case (addr_lo)
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            2'd3:    w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    load_data = {{16{w_half[15]}}, w_half};
            F3_BU:   load_data = {24'd0, w_byte};
            F3_HU:   load_data = {16'd0, w_half};
            default: load_data = rdata;
        endcase
    end

endmodule : lsu_load_align
`default_nettype wire

// File: rtl/lsu_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_dmem_ctrl
//  Description : MEM-stage load/store unit. Issues loads/stores over a
//                req/gnt/rvalid handshake, stalls the pipeline until the
//                access finishes, formats load data, flags misaligned and
//                timed-out accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_dmem_ctrl
    import lsu_dmem_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_mem,
    input  logic        valid_mem,
    input  logic        flush,
    input  logic [31:0] addr_mem,
    input  logic [31:0] wdata_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        lsu_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign_err,
    output logic        timeout_err
);

    lsu_state_t        r_state, w_next;
    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic              w_is_load, w_is_store, w_mem_op, w_aligned, w_start;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       r_addr, r_wdata, r_load_data;
    logic [3:0]        r_be;
    logic [2:0]        r_funct3;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_misalign, r_timeout;
    logic              w_cnt_last, w_capture, w_timeout;
    logic [31:0]       w_fmt;
    logic              w_unused;

    assign w_opcode   = instr_mem[6:0];
    assign w_funct3   = instr_mem[14:12];
    assign w_unused   = &{1'b0, instr_mem[31:15], instr_mem[11:7]};
    assign w_is_load  = (w_opcode == OPC_LOAD);
    assign w_is_store = (w_opcode == OPC_STORE);
    assign w_mem_op   = valid_mem & (w_is_load | w_is_store);
    assign w_aligned  = is_aligned(w_funct3[1:0], addr_mem[1:0]);
    assign w_start    = (r_state == IDLE) & w_mem_op & w_aligned & ~flush;
    assign w_cnt_last = (r_cnt == CNT_W'(MAX_WAIT - 1));

    // Byte enables and lane-replicated write data for the incoming access
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata_mem;
        case (w_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr_mem[1:0];
                w_wdata = {4{wdata_mem[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {addr_mem[1], 1'b0};
                w_wdata = {2{wdata_mem[15:0]}};
            end
            default: ;
        endcase
    end

    lsu_load_align u_align (
        .funct3    (r_funct3),
        .addr_lo   (r_addr[1:0]),
        .rdata     (dmem_rdata),
        .load_data (w_fmt)
    );

    // Next-state logic; timeout only fires when the current cycle does not complete
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) w_next = REQ;
            end
            REQ: begin
                if (flush) begin
                    w_next = IDLE;
                end else if (dmem_gnt & (r_we | dmem_rvalid)) begin
                    w_next    = DONE;
                    w_capture = ~r_we;
                end else if (w_cnt_last) begin
                    w_next    = IDLE;
                    w_timeout = 1'b1;
                end else if (dmem_gnt) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    w_next    = flush ? IDLE : DONE;
                    w_capture = ~flush;
                end else if (w_cnt_last) begin
                    w_next    = IDLE;
                    w_timeout = 1'b1;
                end else if (flush) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (dmem_rvalid) begin
                    w_next = IDLE;
                end else if (w_cnt_last) begin
                    w_next    = IDLE;
                    w_timeout = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Capture the access so the bus fields stay stable while the pipeline is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
            r_we     <= 1'b0;
        end else if (w_start) begin
            r_addr   <= addr_mem;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_funct3 <= w_funct3;
            r_we     <= w_is_store;
        end
    end

    // Wait counter: cleared on issue, runs while an access is outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_start)
            r_cnt <= '0;
        else if (r_state == REQ || r_state == WAIT || r_state == DRAIN)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    // Load result register and one-cycle error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_data <= '0;
            r_misalign  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_capture) r_load_data <= w_fmt;
            r_misalign <= (r_state == IDLE) & w_mem_op & ~w_aligned;
            r_timeout  <= w_timeout;
        end
    end

    assign dmem_req     = (r_state == REQ);
    assign dmem_we      = r_we;
    assign dmem_be      = r_be;
    assign dmem_addr    = {r_addr[31:2], 2'b00};
    assign dmem_wdata   = r_wdata;
    assign lsu_stall    = w_start | (r_state == REQ) | (r_state == WAIT) | (r_state == DRAIN);
    assign load_data    = r_load_data;
    assign load_valid   = (r_state == DONE) & ~r_we;
    assign misalign_err = r_misalign;
    assign timeout_err  = r_timeout;

endmodule : lsu_dmem_ctrl
`default_nettype wire
